decode_pipe: RTL and testbench
==============================

# decode_pipe

Registered, parametrised RV32/RV64 instruction decode stage. It takes fetched instructions over a valid/ready handshake and splits them into register/function fields and a sign-extended immediate selected by opcode. It also classifies the instruction format, flags illegal encodings and buffers results in a 2-entry skid FIFO. It sits between fetch and the register-read/execute stage and supersedes the purely combinational decoder.

## Interface
- XLEN, 32, immediate and PC width; legal values 32 or 64
- RV64, (XLEN==64), enables OP-IMM-32 / OP-32 opcodes
- iClk  in  1  clock, rising edge
- iRstN  in  1  asynchronous active-low reset
- iFlush  in  1  synchronous flush of all buffered entries
- iValid  in  1  upstream instruction valid
- oReady  out  1  stage can accept (FIFO count < 2)
- iInstr  in  32  instruction word
- iPc  in  XLEN  instruction address, passed through
- oValid  out  1  head entry valid
- iReady  in  1  downstream accepts head
- oOpcode  out  7  instr[6:0]
- oRd  out  5  instr[11:7]
- oFunct3  out  3  instr[14:12]
- oRs1  out  5  instr[19:15]
- oRs2  out  5  instr[24:20]
- oFunct7  out  7  instr[31:25]
- oImm  out  XLEN  sign-extended immediate
- oFmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
- oIllegal  out  1  unrecognised opcode
- oPc  out  XLEN  passthrough of iPc

## Operation
- Decode is combinational on iInstr. The decoded bundle is written into the FIFO on accept (iValid && oReady).
- Register fields are always raw bit slices, regardless of format.
- Opcode map:
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - if RV64: 0011011 → I, 0111011 → R
  - anything else, including instr[1:0]≠11 → ILL with oIllegal=1
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R and ILL: 0
- FIFO: 2 entries, in-order.
  - Head is presented on the outputs; pop on oValid && iReady.
  - Push and pop in the same cycle is legal at any count.
- Flush:
  - Count goes to 0 at the next edge.
  - A push in the flush cycle is discarded.
  - Flush overrides simultaneous push/pop.
- Reset (async, any time, including mid-transfer):
  - count=0, oValid=0, oReady=1.
  - All data outputs = 0 (oFmt=0).

## Timing
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, with oValid=1 in cycle N+1.
- Throughput: 1 instruction/cycle when iReady is held high.
- oReady depends on registered count only; there is no combinational path from iReady to oReady.
- Count transitions:
  - 0 → 1 on push
  - 1 → 2 on push without pop
  - 2 → 1 on pop
  - 1 → 0 on pop without push
  - count=2 with push and pop: push is blocked because oReady=0; pop takes it to 1.
- Data outputs hold stable while oValid && !iReady.
- Data outputs when oValid=0: don't-care, but must not be X after reset.

## Structure
- Shared package decode_pkg holds:
  - opcode localparams
  - fmt_e enum (R, I, S, B, U, J, ILL)
  - decoded bundle struct {opcode, rd, funct3, rs1, rs2, funct7, imm, fmt, illegal, pc}
- Sub-module decode_comb: combinational field/immediate/format extraction, parametrised by XLEN/RV64.
- decode_pipe instantiates decode_comb and holds the 2-entry FIFO with its count/pointer logic.

## Test plan
- Reset with iRstN=0 mid-stream → oValid=0, oReady=1, all outputs 0 immediately and asynchronously.
- iInstr=0xFFF00093 (addi x1,x0,-1), XLEN=32 → oOpcode=0x13, oRd=1, oFmt=I, oImm=0xFFFFFFFF one cycle later.
- Back-to-back formats:
  - 0x0020A423 (sw) → S, imm 0x8
  - 0xFE000EE3 (beq) → B, imm 0xFFFFFFFC
  - 0x123452B7 (lui) → U, imm 0x12345000
  - 0x001000EF (jal) → J, imm 0x800
  - all at 1/cycle with iReady=1.
- Backpressure:
  - iReady=0, push 3 instructions → oReady falls after 2 accepts and the third is held upstream.
  - Release iReady → in-order delivery and oPc matches each instruction.
- Illegal input:
  - 0x00000000 → oIllegal=1, oFmt=7, oImm=0.
  - 0x0000003B with XLEN=32 → illegal; with XLEN=64 → R.
- Flush with 2 entries buffered plus a simultaneous push → oValid=0 next cycle and nothing from the flushed set is ever emitted.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and opcode constants for the RV32/RV64 decode stage.
package decode_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    // imm/pc are sized for the widest XLEN; narrower builds use the low bits.
    typedef struct packed {
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          funct7;
        logic [XLEN_MAX-1:0] imm;
        fmt_e                fmt;
        logic                illegal;
        logic [XLEN_MAX-1:0] pc;
    } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational field, format and immediate extraction for one instruction.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit RV64 = (XLEN == 64)
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output dec_t            dec
);

    fmt_e fmt;

    always_comb begin
        case (instr[6:0])
            OPC_OP:                 fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
            OPC_STORE:              fmt = FMT_S;
            OPC_BRANCH:             fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:     fmt = FMT_U;
            OPC_JAL:                fmt = FMT_J;
            OPC_OP_IMM_32:          fmt = RV64 ? FMT_I : FMT_ILL;
            OPC_OP_32:              fmt = RV64 ? FMT_R : FMT_ILL;
            default:                fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.opcode  = instr[6:0];
        dec.rd      = instr[11:7];
        dec.funct3  = instr[14:12];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.funct7  = instr[31:25];
        dec.fmt     = fmt;
        dec.illegal = (fmt == FMT_ILL);
        dec.pc[XLEN-1:0] = pc;
        // Sign-extend to the full struct width; truncation to XLEN keeps it correct.
        case (fmt)
            FMT_I:   dec.imm = {{52{instr[31]}}, instr[31:20]};
            FMT_S:   dec.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   dec.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            FMT_U:   dec.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_J:   dec.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default: dec.imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage: combinational decode feeding a 2-entry skid FIFO.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit RV64 = (XLEN == 64)
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iFlush,
    input  logic            iValid,
    output logic            oReady,
    input  logic [31:0]     iInstr,
    input  logic [XLEN-1:0] iPc,
    output logic            oValid,
    input  logic            iReady,
    output logic [6:0]      oOpcode,
    output logic [4:0]      oRd,
    output logic [2:0]      oFunct3,
    output logic [4:0]      oRs1,
    output logic [4:0]      oRs2,
    output logic [6:0]      oFunct7,
    output logic [XLEN-1:0] oImm,
    output logic [2:0]      oFmt,
    output logic            oIllegal,
    output logic [XLEN-1:0] oPc
);

    dec_t       dec_in;
    dec_t       head;
    dec_t       mem_q [2];
    dec_t       mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    decode_comb #(.XLEN(XLEN), .RV64(RV64)) u_decode_comb (
        .instr (iInstr),
        .pc    (iPc),
        .dec   (dec_in)
    );

    assign oReady = (count_q != 2'd2);
    assign oValid = (count_q != 2'd0);
    assign push   = iValid && oReady && !iFlush;
    assign pop    = oValid && iReady && !iFlush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iFlush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec_in;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    // Storage is reset too so the outputs read as zero rather than X after reset.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign oOpcode  = head.opcode;
    assign oRd      = head.rd;
    assign oFunct3  = head.funct3;
    assign oRs1     = head.rs1;
    assign oRs2     = head.rs2;
    assign oFunct7  = head.funct7;
    assign oImm     = head.imm[XLEN-1:0];
    assign oFmt     = head.fmt;
    assign oIllegal = head.illegal;
    assign oPc      = head.pc[XLEN-1:0];

    if (XLEN < XLEN_MAX) begin : g_narrow
        logic unused_hi;
        assign unused_hi = ^{head.imm[XLEN_MAX-1:XLEN], head.pc[XLEN_MAX-1:XLEN]};
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: RV32 and RV64 instances on shared stimulus vs. a queue model.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;

    logic        r32, v32, ill32;
    logic [6:0]  opc32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32, fmt32;
    logic [31:0] imm32, pc32;

    logic        r64, v64, ill64;
    logic [6:0]  opc64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, fmt64;
    logic [63:0] imm64, pc64;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
    } item_t;
    item_t q[$];

    always #5 clk = ~clk;

    decode_pipe #(.XLEN(32)) dut32 (
        .iClk(clk), .iRstN(rst_n), .iFlush(flush), .iValid(valid), .oReady(r32),
        .iInstr(instr), .iPc(pc[31:0]), .oValid(v32), .iReady(ready),
        .oOpcode(opc32), .oRd(rd32), .oFunct3(f3_32), .oRs1(rs1_32), .oRs2(rs2_32),
        .oFunct7(f7_32), .oImm(imm32), .oFmt(fmt32), .oIllegal(ill32), .oPc(pc32)
    );

    decode_pipe #(.XLEN(64)) dut64 (
        .iClk(clk), .iRstN(rst_n), .iFlush(flush), .iValid(valid), .oReady(r64),
        .iInstr(instr), .iPc(pc), .oValid(v64), .iReady(ready),
        .oOpcode(opc64), .oRd(rd64), .oFunct3(f3_64), .oRs1(rs1_64), .oRs2(rs2_64),
        .oFunct7(f7_64), .oImm(imm64), .oFmt(fmt64), .oIllegal(ill64), .oPc(pc64)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int ref_fmt(logic [31:0] ins, bit rv64);
        if (ins[1:0] != 2'b11) return 7;
        case (ins[6:0])
            7'h33:                         return 0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 1;
            7'h23:                         return 2;
            7'h63:                         return 3;
            7'h37, 7'h17:                  return 4;
            7'h6F:                         return 5;
            7'h1B:                         return rv64 ? 1 : 7;
            7'h3B:                         return rv64 ? 0 : 7;
            default:                       return 7;
        endcase
    endfunction

    // Two's-complement value of a w-bit field.
    function automatic longint sval(longint unsigned v, int w);
        if (((v >> (w - 1)) & 1) != 0) return longint'(v) - (longint'(1) << w);
        return longint'(v);
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] ins, int xlen);
        longint r;
        case (ref_fmt(ins, xlen == 64))
            1:       r = sval(64'(ins[31:20]), 12);
            2:       r = sval(64'({ins[31:25], ins[11:7]}), 12);
            3:       r = sval(64'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12) * 2;
            4:       r = sval(64'(ins[31:12]), 20) * 4096;
            5:       r = sval(64'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20) * 2;
            default: r = 0;
        endcase
        if (xlen == 32) return 64'(r) & 64'hFFFF_FFFF;
        return 64'(r);
    endfunction

    task automatic check_dut(string p, int xlen, logic rdy, logic vld, logic [6:0] opc,
                             logic [4:0] rd, logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                             logic [6:0] f7, logic [63:0] imm, logic [2:0] fmt, logic ill,
                             logic [63:0] pcv);
        logic [31:0] ins;
        logic [63:0] epc;
        int          ef;
        check({p, "_ready"}, 64'(rdy), 64'(q.size() < 2));
        check({p, "_valid"}, 64'(vld), 64'(q.size() > 0));
        if (q.size() > 0) begin
            ins = q[0].ins;
            epc = (xlen == 32) ? (q[0].pc & 64'hFFFF_FFFF) : q[0].pc;
            ef  = ref_fmt(ins, xlen == 64);
            check({p, "_opcode"}, 64'(opc), 64'(ins[6:0]));
            check({p, "_rd"},     64'(rd),  64'(ins[11:7]));
            check({p, "_funct3"}, 64'(f3),  64'(ins[14:12]));
            check({p, "_rs1"},    64'(rs1), 64'(ins[19:15]));
            check({p, "_rs2"},    64'(rs2), 64'(ins[24:20]));
            check({p, "_funct7"}, 64'(f7),  64'(ins[31:25]));
            check({p, "_fmt"},    64'(fmt), 64'(ef));
            check({p, "_illegal"}, 64'(ill), 64'(ef == 7));
            check({p, "_imm"},    imm, ref_imm(ins, xlen));
            check({p, "_pc"},     pcv, epc);
        end
    endtask

    task automatic check_all();
        check_dut("x32", 32, r32, v32, opc32, rd32, f3_32, rs1_32, rs2_32, f7_32,
                  64'(imm32), fmt32, ill32, 64'(pc32));
        check_dut("x64", 64, r64, v64, opc64, rd64, f3_64, rs1_64, rs2_64, f7_64,
                  imm64, fmt64, ill64, pc64);
    endtask

    task automatic check_reset_state(string p);
        check({p, "_rst_valid32"}, 64'(v32), 64'd0);
        check({p, "_rst_ready32"}, 64'(r32), 64'd1);
        check({p, "_rst_fields32"},
              64'({opc32, rd32, f3_32, rs1_32, rs2_32, f7_32, fmt32, ill32}), 64'd0);
        check({p, "_rst_imm_pc32"}, {imm32, pc32}, 64'd0);
        check({p, "_rst_valid64"}, 64'(v64), 64'd0);
        check({p, "_rst_ready64"}, 64'(r64), 64'd1);
        check({p, "_rst_fields64"},
              64'({opc64, rd64, f3_64, rs1_64, rs2_64, f7_64, fmt64, ill64}), 64'd0);
        check({p, "_rst_imm64"}, imm64, 64'd0);
        check({p, "_rst_pc64"}, pc64, 64'd0);
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the model at the edge.
    task automatic step(bit v, logic [31:0] ins, logic [63:0] p, bit rdy, bit fl);
        bit push_ok, pop_ok;
        valid = v; instr = ins; pc = p; ready = rdy; flush = fl;
        @(negedge clk);
        check_all();
        push_ok = v && (q.size() < 2) && !fl;
        pop_ok  = rdy && (q.size() > 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop_ok) void'(q.pop_front());
            if (push_ok) q.push_back('{ins: ins, pc: p});
        end
    endtask

    logic [31:0] b2b_ins [4] = '{32'h0020A423, 32'hFE000EE3, 32'h123452B7, 32'h001000EF};
    int          b2b_fmt [4] = '{2, 3, 4, 5};
    logic [31:0] b2b_imm [4] = '{32'h0000_0008, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0800};
    logic [6:0]  opcs [15] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h1B, 7'h3B, 7'h00, 7'h7F};

    initial begin
        logic [31:0] r;

        #2;
        check_reset_state("init");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi x1, x0, -1
        step(1, 32'hFFF00093, 64'h1000, 1, 0);
        check("addi_opcode", 64'(opc32), 64'h13);
        check("addi_rd", 64'(rd32), 64'd1);
        check("addi_fmt", 64'(fmt32), 64'd1);
        check("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);
        check("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int i = 0; i < 4; i++) begin
            step(1, b2b_ins[i], 64'h2000 + 64'(4 * i), 1, 0);
            check("b2b_valid", 64'(v32), 64'd1);
            check("b2b_fmt", 64'(fmt32), 64'(b2b_fmt[i]));
            check("b2b_imm", 64'(imm32), 64'(b2b_imm[i]));
        end
        step(0, '0, '0, 1, 0);

        // Backpressure: third push is held upstream.
        step(1, 32'h00100093, 64'h3000, 0, 0);
        step(1, 32'h00200113, 64'h3004, 0, 0);
        check("bp_ready_full", 64'(r32), 64'd0);
        step(1, 32'h00300193, 64'h3008, 0, 0);
        check("bp_depth", 64'(q.size()), 64'd2);
        for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);
        check("bp_drained", 64'(v32), 64'd0);

        step(1, 32'h0000_0000, 64'h4000, 1, 0);
        check("ill_zero_flag", 64'(ill32), 64'd1);
        check("ill_zero_fmt", 64'(fmt32), 64'd7);
        check("ill_zero_imm", 64'(imm32), 64'd0);
        step(1, 32'h0000_003B, 64'h4004, 1, 0);
        check("op32_fmt_rv32", 64'(fmt32), 64'd7);
        check("op32_ill_rv32", 64'(ill32), 64'd1);
        check("op32_fmt_rv64", 64'(fmt64), 64'd0);
        check("op32_ill_rv64", 64'(ill64), 64'd0);
        step(0, '0, '0, 1, 0);

        // Flush with two buffered and a simultaneous push.
        step(1, 32'h00500293, 64'h5000, 0, 0);
        step(1, 32'h00600313, 64'h5004, 0, 0);
        step(1, 32'h00700393, 64'h5008, 1, 1);
        check("flush_valid", 64'(v32), 64'd0);
        check("flush_ready", 64'(r32), 64'd1);
        for (int i = 0; i < 2; i++) step(0, '0, '0, 1, 0);

        // Asynchronous reset in the middle of a cycle with entries buffered.
        step(1, 32'h00800413, 64'h6000, 0, 0);
        step(1, 32'h00900493, 64'h6004, 0, 0);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check_reset_state("mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            if ($urandom_range(0, 9) != 0) r[6:0] = opcs[$urandom_range(0, 14)];
            step($urandom_range(0, 3) != 0, r, {$urandom(), $urandom()},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end
        for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
